hazard_stall_ctrl: RTL and testbench

- Central pipeline-stall sequencer for the 5-stage core.
- Detects load-use hazards and drives the bubble-insertion select of the ID/EX control-zeroing mux.
- Freezes the pipeline while the data memory has not acknowledged an access, and aborts hangs after a programmable timeout.
- Generates PC / IF-ID write enables and the IF-ID flush for taken branches.

---
 rtl/hazard_stall_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Central pipeline-stall sequencer for the 5-stage core.
//   * Load-use hazard detection: bubble select for the ID/EX control mux.
//   * Data-memory hold: freezes all pipeline registers and the PC while an
//     access in MEM has not been acknowledged. A hang is aborted after
//     MEM_TIMEOUT consecutive hold cycles (0 disables the timeout).
//   * PC / IF-ID write enables and the IF-ID flush for taken branches.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cnt_o / hold_cnt_o are saturating performance counters
//   undefined -> no counter registers, both outputs tied to 0
//
// Parameters
//   MEM_TIMEOUT  consecutive hold cycles before abort (0 = never abort)
//   CNT_W        width of the performance counters
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ID_rs1_i, ID_rs2_i    source registers of the instruction in ID
//   EX_MemRead_i          instruction in EX is a load
//   EX_Rd_addr_i          destination of the instruction in EX
//   MEM_MemRead_i         load in MEM
//   MEM_MemWrite_i        store in MEM
//   mem_ready_i           data memory acknowledge, same cycle
//   branch_taken_i        branch resolved taken in ID
//   stall_o               zero the ID/EX control (bubble insert)
//   PCWrite_o             PC write enable
//   IFIDWrite_o           IF/ID write enable
//   flush_o               IF/ID flush
//   pipe_hold_o           freeze all pipeline registers and PC
//   err_o                 sticky memory-timeout flag (cleared only by reset)
//   stall_cnt_o           load-use bubble cycles
//   hold_cnt_o            memory-hold cycles
//   state_dbg_o           FSM state: 0 = RUN, 1 = WAIT, 2 = ABORT
//
// All control outputs are combinational from state and inputs (zero latency).
// Priority: memory hold > load-use > branch flush.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_Rd_addr_i,
  input  logic             MEM_MemRead_i,
  input  logic             MEM_MemWrite_i,
  input  logic             mem_ready_i,
  input  logic             branch_taken_i,
  output logic             stall_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             flush_o,
  output logic             pipe_hold_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] hold_cnt_o,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  // Wait counter only has to reach MEM_TIMEOUT; keep at least one bit.
  localparam int             WCW         = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);
  localparam bit             TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  state_t         state_q, state_nxt;
  logic [WCW-1:0] wait_q, wait_nxt;
  logic           err_q;
  logic           err_set;
  logic           lu;
  logic           macc;
  logic           hold;

  assign lu   = EX_MemRead_i && (EX_Rd_addr_i != 5'd0) &&
                ((EX_Rd_addr_i == ID_rs1_i) || (EX_Rd_addr_i == ID_rs2_i));
  assign macc = MEM_MemRead_i | MEM_MemWrite_i;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state_q;
    wait_nxt    = '0;
    err_set     = 1'b0;
    hold        = 1'b0;
    stall_o     = 1'b0;
    flush_o     = 1'b0;
    pipe_hold_o = 1'b0;
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;

    unique case (state_q)
      ST_RUN: begin
        hold = macc & ~mem_ready_i;
        if (hold) begin
          state_nxt = ST_WAIT;
          wait_nxt  = WCW'(1);
        end
      end
      ST_WAIT: begin
        // macc dropping while frozen should not happen; it counts as ready.
        hold = macc & ~mem_ready_i;
        if (hold) begin
          wait_nxt = (wait_q == '1) ? wait_q : wait_q + WCW'(1);
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_ABORT: begin
        // Single release cycle: hold forced low whatever mem_ready_i says.
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    // Abort when the consecutive-hold count reaches the limit.
    if (hold && TIMEOUT_EN && (wait_nxt == TIMEOUT_VAL)) begin
      state_nxt = ST_ABORT;
      wait_nxt  = '0;
      err_set   = 1'b1;
    end

    // Output priority; reset releases everything in the same cycle.
    if (rst_i) begin
      stall_o     = 1'b0;
      pipe_hold_o = 1'b0;
    end else if (hold) begin
      pipe_hold_o = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (lu) begin
      // A simultaneous taken branch is dropped; it re-resolves next cycle.
      stall_o     = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else begin
      flush_o     = branch_taken_i;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o       = err_q;
  assign state_dbg_o = state_q;

  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] hold_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      if (stall_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (pipe_hold_o && (hold_cnt_q != '1)) begin
        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign hold_cnt_o  = hold_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign hold_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Directed scenarios followed by randomized traffic. The reference model
// tracks the number of consecutive held cycles and whether the previous cycle
// hit the timeout, and derives every expected output from those plus the
// current inputs. Inputs change on the falling edge and outputs are sampled
// 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 16;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // clock / reset ------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_memread, mem_memread, mem_memwrite, mem_ready, branch_taken;
  logic             stall, pcw, ifidw, flush, pipe_hold, err;
  logic [CNT_W-1:0] stall_cnt, hold_cnt;
  logic [1:0]       state_dbg;

  hazard_stall_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ID_rs1_i      (id_rs1),
    .ID_rs2_i      (id_rs2),
    .EX_MemRead_i  (ex_memread),
    .EX_Rd_addr_i  (ex_rd),
    .MEM_MemRead_i (mem_memread),
    .MEM_MemWrite_i(mem_memwrite),
    .mem_ready_i   (mem_ready),
    .branch_taken_i(branch_taken),
    .stall_o       (stall),
    .PCWrite_o     (pcw),
    .IFIDWrite_o   (ifidw),
    .flush_o       (flush),
    .pipe_hold_o   (pipe_hold),
    .err_o         (err),
    .stall_cnt_o   (stall_cnt),
    .hold_cnt_o    (hold_cnt),
    .state_dbg_o   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // reference model ----------------------------------------------------------
  typedef struct packed {
    logic stall;
    logic pcw;
    logic ifidw;
    logic flush;
    logic hold;
  } ctl_t;

  int m_len;        // consecutive held cycles so far
  bit m_abort;      // previous cycle reached the timeout
  bit m_err;
  int m_stall_cnt;
  int m_hold_cnt;

  function automatic ctl_t model_ctl();
    ctl_t c;
    bit   lu, hold;
    c = '{stall: 1'b0, pcw: 1'b1, ifidw: 1'b1, flush: 1'b0, hold: 1'b0};
    if (rst) return c;
    lu   = ex_memread && (ex_rd != 0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    hold = (mem_memread || mem_memwrite) && !mem_ready && !m_abort;
    if (hold) begin
      c.hold = 1'b1; c.pcw = 1'b0; c.ifidw = 1'b0;
    end else if (lu) begin
      c.stall = 1'b1; c.pcw = 1'b0; c.ifidw = 1'b0;
    end else begin
      c.flush = branch_taken;
    end
    return c;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_abort) return 2'd2;
    if (m_len > 0) return 2'd1;
    return 2'd0;
  endfunction

  // driver tasks -------------------------------------------------------------
  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
    mem_memread = 1'b0; mem_memwrite = 1'b0; mem_ready = 1'b1;
    branch_taken = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic tick();
    ctl_t c;
    c = model_ctl();
    @(posedge clk);
    if (rst) begin
      m_len = 0; m_abort = 1'b0; m_err = 1'b0; m_stall_cnt = 0; m_hold_cnt = 0;
    end else begin
      if (PERF && c.stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (PERF && c.hold && m_hold_cnt < CNT_MAX) m_hold_cnt++;
      if (c.hold) begin
        m_len++;
        if (MEM_TIMEOUT != 0 && m_len == MEM_TIMEOUT) begin
          m_abort = 1'b1; m_err = 1'b1; m_len = 0;
        end else begin
          m_abort = 1'b0;
        end
      end else begin
        m_len = 0; m_abort = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // scenarios ----------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    mem_memread = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    #1;
    checks++; if ({stall, pipe_hold, flush} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl: stall/hold/flush=%b expected 000", {stall, pipe_hold, flush});
    end
    checks++; if ({pcw, ifidw} !== 2'b11) begin
      errors++; $display("FAIL reset_we: pcw/ifidw=%b expected 11", {pcw, ifidw});
    end
    tick();
    set_idle();
    #1;
    checks++; if (state_dbg !== 2'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_state: state=%0d err=%b expected 0/0", state_dbg, err);
    end
    checks++; if (stall_cnt !== '0 || hold_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: stall_cnt=%0d hold_cnt=%0d expected 0/0", stall_cnt, hold_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd9;
    #1;
    checks++; if ({stall, pcw, ifidw} !== 3'b100) begin
      errors++; $display("FAIL lu_rs1: stall/pcw/ifidw=%b expected 100", {stall, pcw, ifidw});
    end
    tick();
    set_idle();
    #1;
    checks++; if (stall !== 1'b0 || pcw !== 1'b1) begin
      errors++; $display("FAIL lu_clear: stall=%b pcw=%b expected 0/1", stall, pcw);
    end
    checks++; if (stall_cnt !== (PERF ? CNT_W'(1) : CNT_W'(0))) begin
      errors++; $display("FAIL lu_cnt: stall_cnt=%0d expected %0d", stall_cnt, PERF ? 1 : 0);
    end
    tick();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd1; id_rs2 = 5'd7;
    #1;
    checks++; if ({stall, pcw, ifidw} !== 3'b100) begin
      errors++; $display("FAIL lu_rs2: stall/pcw/ifidw=%b expected 100", {stall, pcw, ifidw});
    end
    tick();
    ex_memread = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_noload: stall=%b expected 0", stall);
    end
    tick();
  endtask

  task automatic test_x0();
    set_idle();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    checks++; if (stall !== 1'b0 || pcw !== 1'b1 || ifidw !== 1'b1) begin
      errors++; $display("FAIL x0_exempt: stall=%b pcw=%b ifidw=%b expected 0/1/1", stall, pcw, ifidw);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int h0;
    h0 = m_hold_cnt;
    set_idle();
    mem_memread = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({pipe_hold, pcw, ifidw} !== 3'b100) begin
        errors++; $display("FAIL wait_hold%0d: hold/pcw/ifidw=%b expected 100", i, {pipe_hold, pcw, ifidw});
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (pipe_hold !== 1'b0 || err !== 1'b0 || state_dbg !== 2'd1) begin
      errors++; $display("FAIL wait_ready: hold=%b err=%b state=%0d expected 0/0/1", pipe_hold, err, state_dbg);
    end
    tick();
    set_idle();
    #1;
    checks++; if (hold_cnt !== (PERF ? CNT_W'(h0 + 3) : CNT_W'(0)) || state_dbg !== 2'd0) begin
      errors++; $display("FAIL wait_cnt: hold_cnt=%0d state=%0d expected %0d/0", hold_cnt, state_dbg, PERF ? h0 + 3 : 0);
    end
    tick();
  endtask

  task automatic test_timeout();
    set_idle();
    mem_memwrite = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      checks++; if (pipe_hold !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL to_hold%0d: hold=%b err=%b expected 1/0", i, pipe_hold, err);
      end
      tick();
    end
    #1;
    checks++; if (pipe_hold !== 1'b0 || err !== 1'b1 || state_dbg !== 2'd2 || pcw !== 1'b1) begin
      errors++; $display("FAIL to_abort: hold=%b err=%b state=%0d pcw=%b expected 0/1/2/1", pipe_hold, err, state_dbg, pcw);
    end
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (err !== 1'b1 || state_dbg !== 2'd0) begin
        errors++; $display("FAIL to_sticky%0d: err=%b state=%0d expected 1/0", i, err, state_dbg);
      end
      tick();
    end
  endtask

  task automatic test_priority();
    set_idle();
    ex_memread = 1'b1; ex_rd = 5'd12; id_rs2 = 5'd12; branch_taken = 1'b1;
    #1;
    checks++; if ({stall, flush, pipe_hold} !== 3'b100) begin
      errors++; $display("FAIL prio_lu_br: stall/flush/hold=%b expected 100", {stall, flush, pipe_hold});
    end
    tick();
    mem_memread = 1'b1; mem_ready = 1'b0;
    #1;
    checks++; if ({stall, flush, pipe_hold} !== 3'b001) begin
      errors++; $display("FAIL prio_hold: stall/flush/hold=%b expected 001", {stall, flush, pipe_hold});
    end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if ({stall, flush, pipe_hold} !== 3'b100) begin
      errors++; $display("FAIL prio_release: stall/flush/hold=%b expected 100", {stall, flush, pipe_hold});
    end
    tick();
    set_idle();
    branch_taken = 1'b1;
    #1;
    checks++; if ({flush, pcw, ifidw, stall} !== 4'b1110) begin
      errors++; $display("FAIL prio_flush: flush/pcw/ifidw/stall=%b expected 1110", {flush, pcw, ifidw, stall});
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    mem_memread = 1'b1; mem_ready = 1'b0;
    #1;
    checks++; if (pipe_hold !== 1'b1) begin
      errors++; $display("FAIL rmw_hold: hold=%b expected 1", pipe_hold);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (pipe_hold !== 1'b0 || pcw !== 1'b1 || ifidw !== 1'b1) begin
      errors++; $display("FAIL rmw_release: hold=%b pcw=%b ifidw=%b expected 0/1/1", pipe_hold, pcw, ifidw);
    end
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    checks++; if (state_dbg !== 2'd0 || err !== 1'b0 || stall_cnt !== '0 || hold_cnt !== '0) begin
      errors++; $display("FAIL rmw_after: state=%0d err=%b stall_cnt=%0d hold_cnt=%0d expected 0/0/0/0",
                         state_dbg, err, stall_cnt, hold_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    ctl_t c;
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      ex_memread   = ($urandom_range(0, 1) == 1);
      mem_memread  = ($urandom_range(0, 3) == 0);
      mem_memwrite = ($urandom_range(0, 3) == 0);
      mem_ready    = ($urandom_range(0, 9) < 4);
      branch_taken = ($urandom_range(0, 2) == 0);
      #1;
      c = model_ctl();
      checks++; if ({stall, pcw, ifidw, flush, pipe_hold} !== c) begin
        errors++; $display("FAIL rnd_ctl[%0d]: stall/pcw/ifidw/flush/hold=%b expected %b", i,
                           {stall, pcw, ifidw, flush, pipe_hold}, c);
      end
      checks++; if (err !== m_err) begin
        errors++; $display("FAIL rnd_err[%0d]: err=%b expected %b", i, err, m_err);
      end
      checks++; if (state_dbg !== model_state()) begin
        errors++; $display("FAIL rnd_state[%0d]: state=%0d expected %0d", i, state_dbg, model_state());
      end
      checks++; if (stall_cnt !== CNT_W'(m_stall_cnt) || hold_cnt !== CNT_W'(m_hold_cnt)) begin
        errors++; $display("FAIL rnd_cnt[%0d]: stall_cnt=%0d hold_cnt=%0d expected %0d/%0d", i,
                           stall_cnt, hold_cnt, m_stall_cnt, m_hold_cnt);
      end
      tick();
    end
    rst = 1'b0;
    set_idle();
  endtask

  // sequence / final report --------------------------------------------------
  initial begin
    rst = 1'b1;
    set_idle();
    m_len = 0; m_abort = 1'b0; m_err = 1'b0; m_stall_cnt = 0; m_hold_cnt = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_x0();
    test_mem_wait();
    test_timeout();
    test_priority();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
